mesh_router: RTL and testbench
==============================

Name: mesh_router

Overview:
- One node of a 2-D mesh network-on-chip, with one instance per tile in a W x H grid (3x3 in the current system).
- Takes 64-bit flits from four neighbour links and from its local CPU.
- Routes each flit with dimension-ordered (X then Y) routing, one registered hop per cycle.
- Delivers flits addressed to this node to the local CPU port and raises a delivery flag.

Parameters:
- COORD_W, 16, width of the position and mesh-size inputs.
- FLIT_W, 64, width of the neighbour link flits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- x_pos  in  16  this node's column, 1-based, 1 is the left edge.
- y_pos  in  16  this node's row, 1-based, 1 is the top row; y grows downward.
- in_left / in_right / in_up / in_down  in  64 each  flits arriving from the neighbours.
- from_cpu  in  32  local injection word.
- mesh_w  in  16  number of columns.
- mesh_h  in  16  number of rows.
- out_left / out_right / out_up / out_down  out  64 each  registered flits to the neighbours.
- to_cpu  out  32  payload of the last flit delivered to this node.
- set_fi  out  1  one-cycle pulse when to_cpu is updated.

Behaviour:
- Flit format:
  - [63:48] dest_x; [47:32] dest_y; [31:0] payload.
  - A flit is valid iff dest_x != 0. An all-zero flit is an idle slot.
- Injection word format:
  - [31:28] dest_x; [27:24] dest_y; [23:0] data.
  - Injected flit = {12'b0, dest_x, 12'b0, dest_y, 8'b0, data}.
- Injection trigger:
  - Inject when from_cpu[31:28] != 0 and from_cpu differs from its value registered on the previous cycle (edge detect).
  - A constant word therefore injects exactly once.
- Discard rule: a valid flit with dest_x > mesh_w, dest_y == 0, or dest_y > mesh_h is silently discarded at the router where it is received.
- Route computation (X-Y), evaluated per flit:
  - dest_x > x_pos -> right.
  - dest_x < x_pos -> left.
  - else dest_y > y_pos -> down.
  - else dest_y < y_pos -> up.
  - else local.
- Arbitration:
  - Fixed priority per output: left input > right > up > down > local injection.
  - The winner is registered onto the output, or to_cpu for local, at the next rising edge.
  - Per-hop latency is 1 cycle.
- Input hold registers:
  - Each of the 5 sources has a 1-entry hold register.
  - A flit that loses arbitration stays held and competes again next cycle.
  - Held flits take priority over newly arriving flits on the same input.
  - While an input's hold register is occupied, a new valid flit arriving on that input is dropped.
- Outputs with no winner in a cycle drive 64'h0.
- Local delivery:
  - to_cpu <= payload of the delivered flit, and it holds that value until the next delivery.
  - set_fi = 1 for exactly that cycle.
- Reset (asynchronous):
  - All out_* = 0, to_cpu = 0, set_fi = 0.
  - Hold registers cleared; previous-from_cpu register cleared.
  - Reset asserted mid-transfer loses all in-flight flits.
- Simultaneous traffic: flits bound for different outputs all advance in the same cycle, so up to 5 transfers per cycle.
- Boundary: a correctly sized mesh never routes off-edge. If a flit is routed toward a non-existent neighbour, it is driven on that output anyway (the system leaves edge outputs unconnected).

Optional Feature:
- Macro YX_ROUTING_EN.
  - When defined, the route order becomes Y first, then X: dest_y compared before dest_x. All other behaviour is unchanged.
  - When undefined, X-Y routing as above.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all out_* = 0, to_cpu = 0, set_fi = 0 immediately.
- Local delivery: node (2,2), in_left = {16'd2, 16'd2, 32'hDEADBEEF} -> next edge to_cpu = 32'hDEADBEEF, set_fi pulses 1 cycle, and to_cpu holds afterwards.
- X-Y forwarding: node (1,1), from_cpu = 32'h33_00002A -> out_right = {16'd3, 16'd3, 32'h2A} after 1 cycle. At node (3,1), in_left with the same flit -> out_down.
- Injection edge: hold from_cpu = 32'h21_000005 for 10 cycles at node (1,1) -> exactly one flit on out_right. Change data to 6 -> one more flit.
- Contention: node (2,2), in_left and in_up both carry flits for dest (3,2) in the same cycle:
  - cycle 1: out_right = left flit.
  - cycle 2: out_right = up flit.
  - a new in_up flit arriving in cycle 2 is dropped.
- Out-of-range: mesh 3x3, flit dest (4,1) on in_left -> all outputs stay 0 and set_fi stays 0. With YX_ROUTING_EN, flit dest (3,3) at (1,1) -> out_down first.

Source files
------------

// File: rtl/mesh_router.sv
// mesh_router: one node of a 2-D mesh NoC. Dimension-ordered routing, one registered hop per cycle.
// Define YX_ROUTING_EN to route Y first, then X (default build routes X first, then Y).

module mesh_router_lane #(
  parameter int COORD_W   = 16,
  parameter int FLIT_W    = 64,
  parameter int NUM_PORTS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COORD_W-1:0]   x_pos,
  input  logic [COORD_W-1:0]   y_pos,
  input  logic [COORD_W-1:0]   mesh_w,
  input  logic [COORD_W-1:0]   mesh_h,
  input  logic [FLIT_W-1:0]    in_flit,
  input  logic                 granted,
  output logic [FLIT_W-1:0]    cand,
  output logic [NUM_PORTS-1:0] req
);
  localparam int P_LEFT  = 0;
  localparam int P_RIGHT = 1;
  localparam int P_UP    = 2;
  localparam int P_DOWN  = 3;
  localparam int P_LOCAL = 4;

  logic [FLIT_W-1:0]  hold_q, hold_d;
  logic [COORD_W-1:0] in_dx, in_dy, dx, dy;
  logic               hold_vld, in_ok, cand_vld;

  assign in_dx    = in_flit[FLIT_W-1 -: COORD_W];
  assign in_dy    = in_flit[FLIT_W-COORD_W-1 -: COORD_W];
  assign hold_vld = |hold_q[FLIT_W-1 -: COORD_W];
  // Out-of-range destinations never enter the hold register, so they vanish here.
  assign in_ok    = (in_dx != '0) && (in_dx <= mesh_w) && (in_dy != '0) && (in_dy <= mesh_h);

  always_comb begin
    cand = '0;
    if (hold_vld)   cand = hold_q;
    else if (in_ok) cand = in_flit;
  end

  assign dx       = cand[FLIT_W-1 -: COORD_W];
  assign dy       = cand[FLIT_W-COORD_W-1 -: COORD_W];
  assign cand_vld = (dx != '0);

  always_comb begin
    req = '0;
    if (cand_vld) begin
`ifdef YX_ROUTING_EN
      if (dy > y_pos)      req[P_DOWN]  = 1'b1;
      else if (dy < y_pos) req[P_UP]    = 1'b1;
      else if (dx > x_pos) req[P_RIGHT] = 1'b1;
      else if (dx < x_pos) req[P_LEFT]  = 1'b1;
      else                 req[P_LOCAL] = 1'b1;
`else
      if (dx > x_pos)      req[P_RIGHT] = 1'b1;
      else if (dx < x_pos) req[P_LEFT]  = 1'b1;
      else if (dy > y_pos) req[P_DOWN]  = 1'b1;
      else if (dy < y_pos) req[P_UP]    = 1'b1;
      else                 req[P_LOCAL] = 1'b1;
`endif
    end
  end

  // A losing candidate is parked and competes again next cycle.
  always_comb hold_d = (cand_vld && !granted) ? cand : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
endmodule

module mesh_router #(
  parameter int COORD_W = 16,
  parameter int FLIT_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic [FLIT_W-1:0]  in_left,
  input  logic [FLIT_W-1:0]  in_right,
  input  logic [FLIT_W-1:0]  in_up,
  input  logic [FLIT_W-1:0]  in_down,
  input  logic [31:0]        from_cpu,
  input  logic [COORD_W-1:0] mesh_w,
  input  logic [COORD_W-1:0] mesh_h,
  output logic [FLIT_W-1:0]  out_left,
  output logic [FLIT_W-1:0]  out_right,
  output logic [FLIT_W-1:0]  out_up,
  output logic [FLIT_W-1:0]  out_down,
  output logic [31:0]        to_cpu,
  output logic               set_fi
);
  localparam int NUM_PORTS = 5;
  localparam int NUM_LINKS = 4;
  localparam int P_LOCAL   = 4;
  localparam int DATA_W    = 32;

  logic [DATA_W-1:0]                   from_cpu_q, from_cpu_d;
  logic [FLIT_W-1:0]                   inj_flit;
  logic [NUM_PORTS-1:0][FLIT_W-1:0]    in_flit, cand;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0]                grant;
  logic [NUM_LINKS-1:0]                taken;
  logic [NUM_LINKS-1:0][FLIT_W-1:0]    out_q, out_d;
  logic [DATA_W-1:0]                   to_cpu_q, to_cpu_d;
  logic                                set_fi_q, set_fi_d;

  assign from_cpu_d = from_cpu;

  // Edge-detected injection: a word held constant injects only once.
  always_comb begin
    inj_flit = '0;
    if ((from_cpu[31:28] != 4'd0) && (from_cpu != from_cpu_q)) begin
      inj_flit[FLIT_W-1 -: COORD_W]         = COORD_W'(from_cpu[31:28]);
      inj_flit[FLIT_W-COORD_W-1 -: COORD_W] = COORD_W'(from_cpu[27:24]);
      inj_flit[DATA_W-1:0]                  = DATA_W'(from_cpu[23:0]);
    end
  end

  assign in_flit = {inj_flit, in_down, in_up, in_right, in_left};

  for (genvar s = 0; s < NUM_PORTS; s++) begin : g_lane
    mesh_router_lane #(
      .COORD_W   (COORD_W),
      .FLIT_W    (FLIT_W),
      .NUM_PORTS (NUM_PORTS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .x_pos   (x_pos),
      .y_pos   (y_pos),
      .mesh_w  (mesh_w),
      .mesh_h  (mesh_h),
      .in_flit (in_flit[s]),
      .granted (grant[s]),
      .cand    (cand[s]),
      .req     (req[s])
    );
  end

  // Fixed priority per output: lowest source index (left) wins.
  always_comb begin
    grant    = '0;
    taken    = '0;
    out_d    = '0;
    to_cpu_d = to_cpu_q;
    set_fi_d = 1'b0;
    for (int o = 0; o < NUM_LINKS; o++) begin
      for (int s = 0; s < NUM_PORTS; s++) begin
        if (!taken[o] && req[s][o]) begin
          taken[o] = 1'b1;
          grant[s] = 1'b1;
          out_d[o] = cand[s];
        end
      end
    end
    for (int s = 0; s < NUM_PORTS; s++) begin
      if (!set_fi_d && req[s][P_LOCAL]) begin
        set_fi_d = 1'b1;
        grant[s] = 1'b1;
        to_cpu_d = cand[s][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      from_cpu_q <= '0;
      out_q      <= '0;
      to_cpu_q   <= '0;
      set_fi_q   <= 1'b0;
    end else begin
      from_cpu_q <= from_cpu_d;
      out_q      <= out_d;
      to_cpu_q   <= to_cpu_d;
      set_fi_q   <= set_fi_d;
    end
  end

  assign out_left  = out_q[0];
  assign out_right = out_q[1];
  assign out_up    = out_q[2];
  assign out_down  = out_q[3];
  assign to_cpu    = to_cpu_q;
  assign set_fi    = set_fi_q;
endmodule

// File: tb/tb_mesh_router.sv
// Bench for mesh_router: directed scenarios plus randomized traffic against a behavioural node model.
module tb_mesh_router;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x_pos = 16'd1, y_pos = 16'd1, mesh_w = 16'd3, mesh_h = 16'd3;
  logic [63:0] in_left = '0, in_right = '0, in_up = '0, in_down = '0;
  logic [31:0] from_cpu = '0;
  logic [63:0] out_left, out_right, out_up, out_down;
  logic [31:0] to_cpu;
  logic        set_fi;

  int checks = 0;
  int errors = 0;

  mesh_router dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
    .in_left(in_left), .in_right(in_right), .in_up(in_up), .in_down(in_down),
    .from_cpu(from_cpu), .mesh_w(mesh_w), .mesh_h(mesh_h),
    .out_left(out_left), .out_right(out_right), .out_up(out_up), .out_down(out_down),
    .to_cpu(to_cpu), .set_fi(set_fi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: one pending flit per input, outputs as seen after the next edge.
  logic [63:0] m_pend [5];
  logic [31:0] m_prev;
  logic [63:0] m_out [4];
  logic [31:0] m_to_cpu;
  logic        m_fi;

  // 0 left, 1 right, 2 up, 3 down, 4 local
  function automatic int dir_of(input logic [63:0] f);
    int dx, dy, px, py;
    dx = int'(f[63:48]); dy = int'(f[47:32]);
    px = int'(x_pos);    py = int'(y_pos);
`ifdef YX_ROUTING_EN
    if (dy > py) return 3;
    if (dy < py) return 2;
    if (dx > px) return 1;
    if (dx < px) return 0;
`else
    if (dx > px) return 1;
    if (dx < px) return 0;
    if (dy > py) return 3;
    if (dy < py) return 2;
`endif
    return 4;
  endfunction

  function automatic bit acceptable(input logic [63:0] f);
    return f[63:48] != 0 && f[63:48] <= mesh_w && f[47:32] != 0 && f[47:32] <= mesh_h;
  endfunction

  task automatic model_step();
    logic [63:0] arr [5];
    logic [63:0] cur [5];
    logic [63:0] inj;
    bit          won [5];
    inj = '0;
    if (from_cpu[31:28] != 0 && from_cpu != m_prev)
      inj = {12'b0, from_cpu[31:28], 12'b0, from_cpu[27:24], 8'b0, from_cpu[23:0]};
    m_prev = from_cpu;
    arr = '{in_left, in_right, in_up, in_down, inj};
    for (int s = 0; s < 5; s++) begin
      won[s] = 0;
      if (m_pend[s][63:48] != 0)  cur[s] = m_pend[s];
      else if (acceptable(arr[s])) cur[s] = arr[s];
      else                         cur[s] = '0;
    end
    for (int o = 0; o < 4; o++) m_out[o] = '0;
    m_fi = 1'b0;
    for (int o = 0; o < 5; o++) begin
      for (int s = 0; s < 5; s++) begin
        if (cur[s][63:48] != 0 && dir_of(cur[s]) == o) begin
          won[s] = 1;
          if (o < 4) m_out[o] = cur[s];
          else begin m_to_cpu = cur[s][31:0]; m_fi = 1'b1; end
          break;
        end
      end
    end
    for (int s = 0; s < 5; s++) m_pend[s] = (cur[s][63:48] != 0 && !won[s]) ? cur[s] : '0;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".left"},   out_left,  m_out[0]);
    chk({tag, ".right"},  out_right, m_out[1]);
    chk({tag, ".up"},     out_up,    m_out[2]);
    chk({tag, ".down"},   out_down,  m_out[3]);
    chk({tag, ".to_cpu"}, {32'b0, to_cpu}, {32'b0, m_to_cpu});
    chk({tag, ".set_fi"}, {63'b0, set_fi}, {63'b0, m_fi});
  endtask

  task automatic clear_inputs();
    in_left = '0; in_right = '0; in_up = '0; in_down = '0; from_cpu = '0;
  endtask

  // Reset is raised mid-cycle and must clear outputs without waiting for an edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    chk("rst.left",   out_left,  64'h0);
    chk("rst.right",  out_right, 64'h0);
    chk("rst.up",     out_up,    64'h0);
    chk("rst.down",   out_down,  64'h0);
    chk("rst.to_cpu", {32'b0, to_cpu}, 64'h0);
    chk("rst.set_fi", {63'b0, set_fi}, 64'h0);
    for (int s = 0; s < 5; s++) m_pend[s] = '0;
    for (int o = 0; o < 4; o++) m_out[o] = '0;
    m_prev = '0; m_to_cpu = '0; m_fi = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd_flit();
    if ($urandom_range(0, 9) < 4) return '0;
    return {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)), 32'($urandom)};
  endfunction

  initial begin
    logic [63:0] lf, uf, nf, fwd;
    int cnt;
    do_reset();

    // Local delivery at (2,2)
    x_pos = 16'd2; y_pos = 16'd2; mesh_w = 16'd3; mesh_h = 16'd3;
    in_left = {16'd2, 16'd2, 32'hDEADBEEF};
    step("loc");
    chk("loc.data", {32'b0, to_cpu}, 64'hDEADBEEF);
    chk("loc.fi",   {63'b0, set_fi}, 64'h1);
    in_left = '0;
    step("loc_idle");
    chk("loc.hold",   {32'b0, to_cpu}, 64'hDEADBEEF);
    chk("loc.fi_off", {63'b0, set_fi}, 64'h0);

    // Injection at (1,1) towards (3,3), then forwarding at (3,1)
    fwd = {16'd3, 16'd3, 32'h2A};
    x_pos = 16'd1; y_pos = 16'd1;
    from_cpu = 32'h3300002A;
    step("inj");
`ifdef YX_ROUTING_EN
    chk("inj.down", out_down, fwd);
`else
    chk("inj.right", out_right, fwd);
`endif
    from_cpu = '0;
    x_pos = 16'd3;
    in_left = fwd;
    step("fwd");
    chk("fwd.down", out_down, fwd);
    in_left = '0;

    // Injection edge detection
    x_pos = 16'd1; y_pos = 16'd1;
    from_cpu = 32'h21000005;
    cnt = 0;
    repeat (10) begin step("edge5"); if (out_right != 0) cnt++; end
    chk("edge.once", 64'(cnt), 64'd1);
    from_cpu = 32'h21000006;
    cnt = 0;
    repeat (10) begin step("edge6"); if (out_right != 0) cnt++; end
    chk("edge.again", 64'(cnt), 64'd1);
    from_cpu = '0;

    // Contention at (2,2): left beats up, up is held, new up flit dropped
    x_pos = 16'd2; y_pos = 16'd2;
    lf = {16'd3, 16'd2, 32'h1111}; uf = {16'd3, 16'd2, 32'h2222}; nf = {16'd3, 16'd2, 32'h3333};
    in_left = lf; in_up = uf;
    step("cont1");
    chk("cont.c1", out_right, lf);
    in_left = '0; in_up = nf;
    step("cont2");
    chk("cont.c2", out_right, uf);
    in_up = '0;
    step("cont3");
    chk("cont.drop", out_right, 64'h0);

    // Out-of-range destinations are discarded
    in_left = {16'd4, 16'd1, 32'h5555};
    step("oor_x");
    chk("oor.right", out_right, 64'h0);
    chk("oor.left",  out_left,  64'h0);
    chk("oor.fi",    {63'b0, set_fi}, 64'h0);
    in_left = {16'd2, 16'd0, 32'h6666};
    step("oor_y0");
    chk("oor.y0_fi", {63'b0, set_fi}, 64'h0);
    in_left = {16'd2, 16'd4, 32'h7777};
    step("oor_yh");
    chk("oor.yh_down", out_down, 64'h0);
    in_left = '0;

    // Route order at (1,1) towards (3,3)
    x_pos = 16'd1; y_pos = 16'd1;
    in_left = {16'd3, 16'd3, 32'h77};
    step("order");
`ifdef YX_ROUTING_EN
    chk("order.down", out_down, {16'd3, 16'd3, 32'h77});
`else
    chk("order.right", out_right, {16'd3, 16'd3, 32'h77});
`endif
    in_left = '0;

    // Reset mid-transfer drops the held flit
    x_pos = 16'd2; y_pos = 16'd2;
    in_left = lf; in_up = uf;
    step("mid1");
    do_reset();
    step("mid2");
    chk("mid.lost", out_right, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        x_pos  = 16'($urandom_range(1, 3)); y_pos  = 16'($urandom_range(1, 3));
        mesh_w = 16'($urandom_range(2, 4)); mesh_h = 16'($urandom_range(2, 4));
      end
      if (i % 150 == 149) do_reset();
      in_left = rnd_flit(); in_right = rnd_flit(); in_up = rnd_flit(); in_down = rnd_flit();
      if ($urandom_range(0, 3) == 0)
        from_cpu = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 24'($urandom)};
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
